fetch_queue: RTL and testbench

- Front-end fetch stage feeding dispatch.
- Owns the PC and issues 4-byte instruction requests to instruction memory over a valid/ready handshake.
- Buffers in-order responses in a small instruction queue and presents one instruction per cycle to dispatch as in_fetch_insnbits/in_fetch_done.
- Handles core stall, branch redirect (flush plus stale-response drop) and halt on HLT.

---
 rtl/fetch_queue.sv | 215 +++++++++++++++++++++
 tb/tb_fetch_queue.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Fetch front end: owns the PC, issues 4-byte imem requests, queues in-order responses for dispatch.
// One edge from response capture to out_fetch_done; issue throttles on queue credits, stall only blocks pops.

module fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    wr_vld,
   input  logic [WIDTH-1:0]        wr_dat,
   input  logic                    rd_vld,
   output logic [WIDTH-1:0]        rd_dat,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             do_wr;
   logic             do_rd;

   assign empty  = (count == '0);
   assign full   = (count == CW'(DEPTH));
   assign do_rd  = rd_vld & ~empty;
   assign do_wr  = wr_vld & (~full | do_rd);
   assign rd_dat = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_wr) - CW'(do_rd);
      end
   end

   // Storage needs no reset: count gates every read.
   always_ff @(posedge clk) begin
      if (do_wr && !flush) mem[wr_ptr] <= wr_dat;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(wr_vld && !flush && full && !rd_vld));
endmodule

module fetch_queue #(
   parameter int          QUEUE_DEPTH  = 4,
   parameter int          MAX_INFLIGHT = 2,
   parameter logic [63:0] RESET_PC     = 64'h0
) (
   input  logic        in_clk,
   input  logic        in_rst_n,
   input  logic        in_stall,
   input  logic        in_redirect_valid,
   input  logic [63:0] in_redirect_pc,
   output logic        out_imem_req_valid,
   output logic [63:0] out_imem_req_addr,
   input  logic        in_imem_req_ready,
   input  logic        in_imem_resp_valid,
   input  logic [31:0] in_imem_resp_data,
   output logic [31:0] out_fetch_insnbits,
   output logic [63:0] out_fetch_pc,
   output logic        out_fetch_done,
   output logic        out_halted
);
   localparam int QW = $clog2(QUEUE_DEPTH) + 1;
   localparam int IW = $clog2(MAX_INFLIGHT) + 1;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] insn;
   } fetch_entry_t;

   typedef enum logic {
      RUN,
      HALTED
   } state_t;

   state_t       state_q;
   state_t       state_d;
   logic [63:0]  pc_q;
   logic [IW-1:0] inflight_q;
   logic [IW-1:0] stale_q;
   logic [IW-1:0] live;
   logic [63:0]  resp_pc;

   logic         run;
   logic         redirect;
   logic         req_fire;
   logic         resp_fire;
   logic         resp_keep;
   logic         pop;
   logic         head_is_hlt;
   logic         credit_ok;

   fetch_entry_t push_ent;
   fetch_entry_t head_ent;
   logic         q_empty;
   logic [QW-1:0] q_count;

   assign run       = (state_q == RUN);
   assign redirect  = in_redirect_valid & run;
   assign req_fire  = out_imem_req_valid & in_imem_req_ready;
   // A response with nothing outstanding (e.g. a leftover from before reset) is ignored.
   assign resp_fire = in_imem_resp_valid & (inflight_q != '0);
   assign resp_keep = resp_fire & (stale_q == '0) & run & ~redirect;
   assign pop       = run & ~in_stall & ~q_empty & ~in_redirect_valid;

   // Live requests were issued back to back ending at pc_q-4, so the oldest sits 4*live below pc_q.
   assign live     = inflight_q - stale_q;
   assign resp_pc  = pc_q - {{(62-IW){1'b0}}, live, 2'b00};
   assign push_ent = '{pc: resp_pc, insn: in_imem_resp_data};

   assign head_is_hlt = (head_ent.insn[31:21] == 11'b110_1010_0010) &&
                        (head_ent.insn[4:0] == 5'b0_0000);

   assign credit_ok = (int'(inflight_q) < MAX_INFLIGHT) &&
                      ((int'(q_count) + int'(inflight_q) - int'(stale_q)) < QUEUE_DEPTH);

   fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (QUEUE_DEPTH)
   ) u_insn_q (
      .clk    (in_clk),
      .rst_n  (in_rst_n),
      .flush  (redirect),
      .wr_vld (resp_keep),
      .wr_dat (push_ent),
      .rd_vld (pop),
      .rd_dat (head_ent),
      .empty  (q_empty),
      .count  (q_count)
   );

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d            = state_q;
      out_imem_req_valid = 1'b0;
      out_imem_req_addr  = pc_q;
      case (state_q)
         RUN: begin
            out_imem_req_valid = ~in_redirect_valid & credit_ok;
            if (pop && head_is_hlt) state_d = HALTED;
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   assign out_halted = (state_q == HALTED);

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         pc_q       <= RESET_PC;
         inflight_q <= '0;
         stale_q    <= '0;
      end else begin
         inflight_q <= inflight_q + IW'(req_fire) - IW'(resp_fire);
         if (redirect) begin
            pc_q    <= in_redirect_pc & ~64'h3;
            // Everything still outstanding after this edge belongs to the old path.
            stale_q <= inflight_q - IW'(resp_fire);
         end else begin
            if (req_fire) pc_q <= pc_q + 64'd4;
            if (resp_fire && stale_q != '0) stale_q <= stale_q - 1'b1;
         end
      end
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         out_fetch_done     <= 1'b0;
         out_fetch_insnbits <= '0;
         out_fetch_pc       <= '0;
      end else begin
         out_fetch_done <= pop;
         if (pop) begin
            out_fetch_insnbits <= head_ent.insn;
            out_fetch_pc       <= head_ent.pc;
         end
      end
   end

   a_stale_le_inflight: assert property (@(posedge in_clk) disable iff (!in_rst_n)
      stale_q <= inflight_q);

   a_req_stable: assert property (@(posedge in_clk) disable iff (!in_rst_n)
      (out_imem_req_valid && !in_imem_req_ready && state_d == RUN)
      |=> (in_redirect_valid ||
           (out_imem_req_valid && out_imem_req_addr == $past(out_imem_req_addr))));
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based reference of the fetch rules.
module tb_fetch_queue;
   localparam logic [63:0] RST_PC = 64'h1000;
   localparam int DEPTH = 4;
   localparam int MAXF  = 2;

   logic        in_clk = 1'b0;
   logic        in_rst_n = 1'b0;
   logic        in_stall = 1'b0;
   logic        in_redirect_valid = 1'b0;
   logic [63:0] in_redirect_pc = '0;
   logic        out_imem_req_valid;
   logic [63:0] out_imem_req_addr;
   logic        in_imem_req_ready = 1'b0;
   logic        in_imem_resp_valid = 1'b0;
   logic [31:0] in_imem_resp_data = '0;
   logic [31:0] out_fetch_insnbits;
   logic [63:0] out_fetch_pc;
   logic        out_fetch_done;
   logic        out_halted;

   fetch_queue #(
      .QUEUE_DEPTH  (DEPTH),
      .MAX_INFLIGHT (MAXF),
      .RESET_PC     (RST_PC)
   ) dut (
      .in_clk             (in_clk),
      .in_rst_n           (in_rst_n),
      .in_stall           (in_stall),
      .in_redirect_valid  (in_redirect_valid),
      .in_redirect_pc     (in_redirect_pc),
      .out_imem_req_valid (out_imem_req_valid),
      .out_imem_req_addr  (out_imem_req_addr),
      .in_imem_req_ready  (in_imem_req_ready),
      .in_imem_resp_valid (in_imem_resp_valid),
      .in_imem_resp_data  (in_imem_resp_data),
      .out_fetch_insnbits (out_fetch_insnbits),
      .out_fetch_pc       (out_fetch_pc),
      .out_fetch_done     (out_fetch_done),
      .out_halted         (out_halted)
   );

   always #5 in_clk = ~in_clk;

   typedef struct { logic [63:0] addr; bit stale; } req_t;
   typedef struct { logic [63:0] pc; logic [31:0] insn; } ent_t;
   typedef struct { logic [63:0] addr; int due; } pend_t;

   req_t  m_out[$];
   ent_t  m_q[$];
   pend_t env_q[$];
   bit          m_run;
   bit          m_done;
   logic [63:0] m_pc;
   logic [63:0] m_opc;
   logic [31:0] m_oinsn;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int max_extra = 0;
   bit resp_hold = 0;
   int pulses;
   logic [63:0] hlt_addr = '1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      if (a == hlt_addr) return 32'hD440_0000;
      if (a == hlt_addr - 64'd4) return 32'hD440_0010;
      return {8'h5A, a[25:2]};
   endfunction

   function automatic void model_reset();
      m_out.delete();
      m_q.delete();
      m_run   = 1'b1;
      m_done  = 1'b0;
      m_pc    = RST_PC;
      m_opc   = '0;
      m_oinsn = '0;
   endfunction

   function automatic bit m_req_vld(input bit redir);
      int live;
      live = 0;
      foreach (m_out[i]) if (!m_out[i].stale) live++;
      return m_run && !redir && (m_out.size() < MAXF) && ((m_q.size() + live) < DEPTH);
   endfunction

   task automatic model_edge(input bit stall, input bit redir, input logic [63:0] rpc,
                             input bit acc, input bit rv);
      bit   run0;
      bit   redir_eff;
      req_t r;
      ent_t e;
      run0      = m_run;
      redir_eff = redir && run0;
      m_done    = 1'b0;
      if (run0 && !stall && !redir && m_q.size() > 0) begin
         e       = m_q.pop_front();
         m_done  = 1'b1;
         m_opc   = e.pc;
         m_oinsn = e.insn;
         if (e.insn ==? 32'b1101_0100_010?_????_????_????_???0_0000) m_run = 1'b0;
      end
      if (rv && m_out.size() > 0) begin
         r = m_out.pop_front();
         if (!r.stale && run0 && !redir_eff) m_q.push_back('{r.addr, mem_word(r.addr)});
      end
      if (redir_eff) begin
         m_q.delete();
         foreach (m_out[i]) m_out[i].stale = 1'b1;
         m_pc = rpc & ~64'h3;
      end else if (acc) begin
         m_out.push_back('{m_pc, 1'b0});
         m_pc = m_pc + 64'd4;
      end
   endtask

   task automatic step(input bit stall, input bit redir, input logic [63:0] rpc, input bit rdy);
      bit          mv;
      bit          rv;
      bit          dut_acc;
      logic [63:0] acc_addr;
      in_stall          = stall;
      in_redirect_valid = redir;
      in_redirect_pc    = rpc;
      in_imem_req_ready = rdy;
      rv = !resp_hold && (env_q.size() > 0) && (env_q[0].due <= cyc);
      in_imem_resp_valid = rv;
      in_imem_resp_data  = rv ? mem_word(env_q[0].addr) : 32'($urandom);
      #1;
      mv = m_req_vld(redir);
      chk("req_vld", out_imem_req_valid, mv);
      if (mv) chk("req_addr", out_imem_req_addr, m_pc);
      dut_acc  = out_imem_req_valid && rdy;
      acc_addr = out_imem_req_addr;
      @(posedge in_clk);
      model_edge(stall, redir, rpc, mv && rdy, rv);
      if (rv) void'(env_q.pop_front());
      cyc++;
      if (dut_acc) env_q.push_back('{acc_addr, cyc + int'($urandom_range(0, max_extra))});
      #1;
      chk("done", out_fetch_done, m_done);
      chk("fetch_pc", out_fetch_pc, m_opc);
      chk("insnbits", out_fetch_insnbits, m_oinsn);
      chk("halted", out_halted, !m_run);
   endtask

   task automatic wait_first(input string tag, input logic [63:0] exp);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         step(0, 0, '0, 1);
         if (out_fetch_done) begin
            seen = 1'b1;
            chk(tag, out_fetch_pc, exp);
         end
      end
      chk({tag, "_seen"}, seen, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit seen;
      model_reset();
      repeat (2) @(posedge in_clk);
      #1;
      chk("rst_done", out_fetch_done, 0);
      chk("rst_pc", out_fetch_pc, 0);
      chk("rst_insn", out_fetch_insnbits, 0);
      chk("rst_halted", out_halted, 0);
      chk("rst_req_addr", out_imem_req_addr, RST_PC);
      in_rst_n = 1'b1;

      // Zero-wait imem: one delivery per cycle from RESET_PC onwards.
      wait_first("first_pc", RST_PC);
      repeat (4) step(0, 0, '0, 1);
      pulses = 0;
      repeat (12) begin
         step(0, 0, '0, 1);
         pulses += int'(out_fetch_done);
      end
      chk("steady_pulses", pulses, 12);

      // Stall fills the queue; release drains it back to back.
      pulses = 0;
      repeat (5) begin
         step(1, 0, '0, 1);
         pulses += int'(out_fetch_done);
      end
      chk("stall_pulses", pulses, 0);
      pulses = 0;
      repeat (4) begin
         step(0, 0, '0, 1);
         pulses += int'(out_fetch_done);
      end
      chk("release_pulses", pulses, 4);

      // Redirect with requests in flight and entries queued; low PC bits ignored.
      resp_hold = 1;
      repeat (3) step(1, 0, '0, 1);
      resp_hold = 0;
      repeat (2) step(1, 0, '0, 0);
      resp_hold = 1;
      repeat (2) step(1, 0, '0, 1);
      step(0, 1, 64'h2002, 1);
      resp_hold = 0;
      wait_first("redir_pc", 64'h2000);

      // Redirect on the same edge as an arriving response, under stall.
      resp_hold = 1;
      repeat (2) step(0, 0, '0, 1);
      resp_hold = 0;
      step(1, 1, 64'h3000, 1);
      wait_first("redir2_pc", 64'h3000);

      // PC wraps modulo 2^64.
      step(0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 1);
      wait_first("wrap_pc", 64'hFFFF_FFFF_FFFF_FFF8);
      repeat (6) step(0, 0, '0, 1);

      // Random traffic: stalls, backpressure, variable latency, redirects.
      max_extra = 3;
      for (int i = 0; i < 3000; i++) begin
         resp_hold = ($urandom_range(0, 9) == 0);
         step($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 3,
              {32'($urandom), 32'($urandom)}, $urandom_range(0, 9) < 7);
      end
      resp_hold = 0;
      max_extra = 0;

      // Async reset mid-burst with two requests outstanding.
      step(0, 1, 64'h4000, 1);
      wait_first("pre_rst_pc", 64'h4000);
      resp_hold = 1;
      repeat (3) step(0, 0, '0, 1);
      in_imem_resp_valid = 1'b0;
      #2;
      in_rst_n = 1'b0;
      #1;
      chk("arst_done", out_fetch_done, 0);
      chk("arst_pc", out_fetch_pc, 0);
      chk("arst_insn", out_fetch_insnbits, 0);
      chk("arst_halted", out_halted, 0);
      model_reset();
      repeat (2) @(posedge in_clk);
      #1;
      in_rst_n  = 1'b1;
      hlt_addr  = RST_PC + 64'hC;
      resp_hold = 0;
      for (int i = 0; i < 20 && env_q.size() > 0; i++) step(0, 0, '0, 0);
      chk("late_resp_drained", env_q.size(), 0);
      wait_first("post_rst_pc", RST_PC);

      // HLT at RESET_PC+0xC (near-miss word just before it must not halt).
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         step(0, 0, '0, 1);
         if (out_halted) begin
            seen = 1'b1;
            chk("hlt_done", out_fetch_done, 1);
            chk("hlt_pc", out_fetch_pc, RST_PC + 64'hC);
            chk("hlt_insn", out_fetch_insnbits, 64'hD440_0000);
         end
      end
      chk("hlt_seen", seen, 1);
      pulses = 0;
      repeat (5) begin
         step(0, 0, '0, 1);
         pulses += int'(out_fetch_done);
      end
      step(0, 1, 64'h8000, 1);
      repeat (5) begin
         step(0, 0, '0, 1);
         pulses += int'(out_fetch_done);
      end
      chk("post_hlt_pulses", pulses, 0);
      chk("post_hlt_halted", out_halted, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
